wave_gen_multi: RTL and testbench

- Parametrised successor to the single-channel square generator.
- Produces square, triangle, sawtooth or DC levels from an explicit period/high-time counter.
- Supports 0°/180° selection, shadowed run-time reconfiguration, and burst mode (N periods, then stop).
- Sits between the scope control registers and the DAC/test-pattern path of the Oscilloscope_test design.

---
 rtl/wave_gen_multi.sv | 200 ++++++++++++++++++++
 tb/tb_wave_gen_multi.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_gen_multi.sv
// Multi-mode waveform generator: square, triangle, sawtooth or DC with shadowed config and burst mode.
// Optional macro WAVE_GEN_SYNC_EN adds sync_in for phase-aligning several instances.
module wave_gen_multi #(
   parameter int DT_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_load,
   input  logic [1:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [DT_W-1:0]  cfg_amp,
   input  logic [DT_W-1:0]  cfg_step,
   input  logic [CNT_W-1:0] cfg_burst,
   input  logic             sel_phase,
`ifdef WAVE_GEN_SYNC_EN
   input  logic             sync_in,
`endif
   output logic [DT_W-1:0]  wave_out,
   output logic             period_start,
   output logic             busy,
   output logic             done
);

   localparam logic [DT_W-1:0] FS = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [1:0]       mode;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] high;
      logic [DT_W-1:0]  amp;
      logic [DT_W-1:0]  step;
      logic [CNT_W-1:0] burst;
   } cfg_t;

   localparam cfg_t CFG_DEFAULT = '{mode: 2'b00, period: CNT_W'(2), high: CNT_W'(1),
                                    amp: '0, step: DT_W'(1), burst: '0};

   state_t           state, state_next;
   cfg_t             act_cfg, pend_cfg, cap_cfg, new_cfg, eff_cfg;
   logic             pend_valid;
   logic [CNT_W-1:0] ph_cnt, per_cnt;
   logic [DT_W-1:0]  acc, acc_next, level, lvl_sel;
   logic [DT_W-1:0]  hi, lo, eff_lo, upper, lower;
   logic [DT_W:0]    sum, diff;
   logic             wrap, last_period, go, restart, sync_rise, apply_cfg;

`ifdef WAVE_GEN_SYNC_EN
   logic sync_d, sync_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_d    <= 1'b0;
         sync_prev <= 1'b0;
      end else begin
         sync_d    <= sync_in;
         sync_prev <= sync_d;
      end
   end

   assign sync_rise = (state == RUN) && sync_d && !sync_prev;
`else
   assign sync_rise = 1'b0;
`endif

   // Capture-time clamping keeps every loaded period at least two cycles with a real low phase
   always_comb begin
      cap_cfg.mode   = cfg_mode;
      cap_cfg.amp    = cfg_amp;
      cap_cfg.step   = cfg_step;
      cap_cfg.burst  = cfg_burst;
      cap_cfg.period = (cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg_period;
      if (cfg_high == '0)
         cap_cfg.high = CNT_W'(1);
      else if (cfg_high >= cap_cfg.period)
         cap_cfg.high = cap_cfg.period - CNT_W'(1);
      else
         cap_cfg.high = cfg_high;
   end

   assign go          = start && !stop;
   assign restart     = (state == RUN) && go;
   assign wrap        = (state == RUN) && (ph_cnt == act_cfg.period - CNT_W'(1));
   assign last_period = wrap && (act_cfg.burst != '0) && (per_cnt == act_cfg.burst - CNT_W'(1));
   assign apply_cfg   = ((state != RUN) || wrap || sync_rise || restart) && (cfg_load || pend_valid);
   assign new_cfg     = cfg_load ? cap_cfg : pend_cfg;
   assign eff_cfg     = apply_cfg ? new_cfg : act_cfg;
   assign busy        = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (go) state_next = RUN;
         RUN: begin
            if (stop)
               state_next = IDLE;
            else if (start)
               state_next = RUN;
            else if (last_period)
               state_next = DONE;
         end
         DONE: begin
            if (stop)
               state_next = IDLE;
            else if (start)
               state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   assign hi     = act_cfg.amp;
   assign lo     = FS - act_cfg.amp;
   assign eff_lo = FS - eff_cfg.amp;
   assign upper  = (hi > lo) ? hi : lo;
   assign lower  = (hi > lo) ? lo : hi;
   assign sum    = {1'b0, acc} + {1'b0, act_cfg.step};
   assign diff   = {1'b0, acc} - {1'b0, act_cfg.step};

   // Ramps saturate at the larger/smaller of hi and lo so amp near FS/2 cannot overshoot
   always_comb begin
      acc_next = acc;
      level    = lo;
      unique case (act_cfg.mode)
         2'b00: level = (ph_cnt < act_cfg.high) ? hi : lo;
         2'b01: begin
            level = acc;
            if (ph_cnt < act_cfg.high)
               acc_next = (sum > {1'b0, upper}) ? upper : sum[DT_W-1:0];
            else
               acc_next = (diff[DT_W] || (diff[DT_W-1:0] < lower)) ? lower : diff[DT_W-1:0];
         end
         2'b10: begin
            level    = acc;
            acc_next = (sum > {1'b0, upper}) ? upper : sum[DT_W-1:0];
         end
         default: level = hi;
      endcase
   end

   assign lvl_sel = (state == RUN) ? level : lo;

   always_ff @(posedge clk) begin
      if (rst) begin
         act_cfg      <= CFG_DEFAULT;
         pend_cfg     <= CFG_DEFAULT;
         pend_valid   <= 1'b0;
         ph_cnt       <= '0;
         per_cnt      <= '0;
         acc          <= '0;
         wave_out     <= '0;
         period_start <= 1'b0;
         done         <= 1'b0;
      end else begin
         if (apply_cfg) begin
            act_cfg    <= new_cfg;
            pend_valid <= 1'b0;
         end else if (cfg_load) begin
            pend_cfg   <= cap_cfg;
            pend_valid <= 1'b1;
         end

         if (go) begin
            ph_cnt  <= '0;
            per_cnt <= '0;
            acc     <= eff_lo;
         end else if (state == RUN) begin
            if (wrap) begin
               ph_cnt <= '0;
               acc    <= eff_lo;
               if (per_cnt != '1)
                  per_cnt <= per_cnt + CNT_W'(1);
            end else if (sync_rise) begin
               ph_cnt <= '0;
               acc    <= eff_lo;
            end else begin
               ph_cnt <= ph_cnt + CNT_W'(1);
               acc    <= acc_next;
            end
         end

         wave_out     <= sel_phase ? (FS - lvl_sel) : lvl_sel;
         period_start <= (state == RUN) && (ph_cnt == '0);
         done         <= (state == RUN) && (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_wave_gen_multi.sv
// Directed testbench for wave_gen_multi: square/phase, triangle, sawtooth, burst, reconfiguration and reset.
module tb_wave_gen_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        cfg_load = 1'b0;
   logic [1:0]  cfg_mode = 2'b00;
   logic [15:0] cfg_period = 16'd2;
   logic [15:0] cfg_high = 16'd1;
   logic [7:0]  cfg_amp = 8'd0;
   logic [7:0]  cfg_step = 8'd1;
   logic [15:0] cfg_burst = 16'd0;
   logic        sel_phase = 1'b0;
   logic        sync_in = 1'b0;
   logic [7:0]  wave_out;
   logic        period_start;
   logic        busy;
   logic        done;

   int vectors = 0;
   int miscompares = 0;

   wave_gen_multi #(.DT_W(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_load(cfg_load),
      .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_high(cfg_high),
      .cfg_amp(cfg_amp), .cfg_step(cfg_step), .cfg_burst(cfg_burst),
      .sel_phase(sel_phase),
`ifdef WAVE_GEN_SYNC_EN
      .sync_in(sync_in),
`endif
      .wave_out(wave_out), .period_start(period_start), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [1:0] m, input logic [15:0] p, input logic [15:0] h,
                           input logic [7:0] a, input logic [7:0] s, input logic [15:0] n);
      cfg_mode = m; cfg_period = p; cfg_high = h; cfg_amp = a; cfg_step = s; cfg_burst = n;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      vectors++;
      if (wave_out !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_state: wave=%0d busy=%b done=%b ps=%b, want 0/0/0/0",
                  wave_out, busy, done, period_start);
      end
      rst = 1'b0;
   endtask

   task automatic test_square;
      logic [7:0] exp_w;
      int ph;
      stop = 1'b1; tick(); stop = 1'b0;
      load_cfg(2'b00, 16'd10, 16'd4, 8'd200, 8'd1, 16'd0);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         ph = k % 10;
         exp_w = (ph < 4) ? 8'd200 : 8'd55;
         vectors++;
         if (wave_out !== exp_w || period_start !== (ph == 0) || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL square k=%0d: wave=%0d ps=%b busy=%b, want %0d/%b/1",
                     k, wave_out, period_start, busy, exp_w, (ph == 0));
         end
      end
   endtask

   task automatic test_phase;
      logic [7:0] lvl, exp_w;
      int ph;
      for (int k = 0; k < 25; k++) begin
         if (k == 5) sel_phase = 1'b1;
         tick();
         ph = k % 10;
         lvl = (ph < 4) ? 8'd200 : 8'd55;
         exp_w = sel_phase ? (8'd255 - lvl) : lvl;
         vectors++;
         if (wave_out !== exp_w || period_start !== (ph == 0)) begin
            miscompares++;
            $display("[TB] FAIL phase k=%0d: wave=%0d ps=%b, want %0d/%b",
                     k, wave_out, period_start, exp_w, (ph == 0));
         end
      end
      sel_phase = 1'b0;
   endtask

   task automatic test_triangle;
      logic [7:0] tri_tab [20];
      tri_tab = '{8'd55, 8'd85, 8'd115, 8'd145, 8'd175, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200,
                  8'd200, 8'd170, 8'd140, 8'd110, 8'd80, 8'd55, 8'd55, 8'd55, 8'd55, 8'd55};
      stop = 1'b1; tick(); stop = 1'b0;
      load_cfg(2'b01, 16'd20, 16'd10, 8'd200, 8'd30, 16'd0);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         vectors++;
         if (wave_out !== tri_tab[k % 20]) begin
            miscompares++;
            $display("[TB] FAIL triangle k=%0d: wave=%0d, want %0d", k, wave_out, tri_tab[k % 20]);
         end
      end
   endtask

   task automatic test_sawtooth;
      logic [7:0] saw_tab [8];
      saw_tab = '{8'd55, 8'd105, 8'd155, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
      stop = 1'b1; tick(); stop = 1'b0;
      load_cfg(2'b10, 16'd8, 16'd4, 8'd200, 8'd50, 16'd0);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 16; k++) begin
         tick();
         vectors++;
         if (wave_out !== saw_tab[k % 8]) begin
            miscompares++;
            $display("[TB] FAIL sawtooth k=%0d: wave=%0d, want %0d", k, wave_out, saw_tab[k % 8]);
         end
      end
   endtask

   task automatic test_burst;
      logic [7:0] exp_w;
      int busy_cycles;
      stop = 1'b1; tick(); stop = 1'b0;
      load_cfg(2'b00, 16'd4, 16'd2, 8'd200, 8'd1, 16'd3);
      start = 1'b1; tick(); start = 1'b0;
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= 11; k++) begin
         tick();
         if (busy === 1'b1) busy_cycles++;
         exp_w = (((k - 1) % 4) < 2) ? 8'd200 : 8'd55;
         vectors++;
         if (wave_out !== exp_w || done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL burst_run k=%0d: wave=%0d done=%b, want %0d/0", k, wave_out, done, exp_w);
         end
      end
      vectors++;
      if (busy_cycles != 12) begin
         miscompares++;
         $display("[TB] FAIL burst_busy_count: got %0d, want 12", busy_cycles);
      end
      tick();
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || wave_out !== 8'd55) begin
         miscompares++;
         $display("[TB] FAIL burst_done: done=%b busy=%b wave=%0d, want 1/0/55", done, busy, wave_out);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || wave_out !== 8'd55) begin
            miscompares++;
            $display("[TB] FAIL burst_after k=%0d: done=%b busy=%b wave=%0d, want 0/0/55",
                     k, done, busy, wave_out);
         end
      end
   endtask

   task automatic test_reconfig;
      logic [7:0] exp_w;
      int ph, hh;
      stop = 1'b1; tick(); stop = 1'b0;
      load_cfg(2'b00, 16'd10, 16'd4, 8'd200, 8'd1, 16'd0);
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 1; k <= 26; k++) begin
         if (k == 3) begin
            cfg_period = 16'd8; cfg_high = 16'd9; cfg_load = 1'b1;
         end
         tick();
         cfg_load = 1'b0;
         if (k <= 10) begin
            ph = k - 1; hh = 4;
         end else begin
            ph = (k - 11) % 8; hh = 7;
         end
         exp_w = (ph < hh) ? 8'd200 : 8'd55;
         vectors++;
         if (wave_out !== exp_w || period_start !== (ph == 0)) begin
            miscompares++;
            $display("[TB] FAIL reconfig k=%0d: wave=%0d ps=%b, want %0d/%b",
                     k, wave_out, period_start, exp_w, (ph == 0));
         end
      end
   endtask

   task automatic test_reset_mid_run;
      logic [7:0] exp_w;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (wave_out !== 8'd0 || busy !== 1'b0 || period_start !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_run: wave=%0d busy=%b ps=%b done=%b, want 0/0/0/0",
                  wave_out, busy, period_start, done);
      end
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         exp_w = ((k % 2) == 0) ? 8'd0 : 8'd255;
         vectors++;
         if (wave_out !== exp_w || period_start !== ((k % 2) == 0)) begin
            miscompares++;
            $display("[TB] FAIL default_shadow k=%0d: wave=%0d ps=%b, want %0d/%b",
                     k, wave_out, period_start, exp_w, ((k % 2) == 0));
         end
      end
   endtask

   task automatic test_start_stop;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_stop_busy: busy=%b, want 0", busy);
      end
      tick();
      vectors++;
      if (wave_out !== 8'd255 || busy !== 1'b0 || period_start !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_stop_idle: wave=%0d busy=%b ps=%b, want 255/0/0",
                  wave_out, busy, period_start);
      end
   endtask

   initial begin
      $display("[TB] wave_gen_multi directed test");
      test_reset();
      test_square();
      test_phase();
      test_triangle();
      test_sawtooth();
      test_burst();
      test_reconfig();
      test_reset_mid_run();
      test_start_stop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
